// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional invalid-digit checking is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_serial_addsub #(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  input  logic                   cin,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned W  = 4 * NDIGITS;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sub_q, sub_d, carry_q, carry_d;
  logic          cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic          mask_c;

  // One decimal digit slice: nines' complement of B for subtract, then +6 correction.
  logic [3:0] bd_c, dig_c;
  logic [4:0] t_c;
  logic       dcarry_c;

  always_comb begin
    bd_c     = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    t_c      = 5'(a_q[3:0]) + 5'(bd_c) + 5'(carry_q);
    dcarry_c = (t_c > 5'd9);
    dig_c    = dcarry_c ? (t_c[3:0] + 4'd6) : t_c[3:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub ? ~cin : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Result digits enter at the top and shift down; digit 0 lands at [3:0].
        sum_d   = (sum_q >> 4) | (W'(dig_c) << (W - 4));
        cout_d  = dcarry_c;
        carry_d = dcarry_c;
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        idx_d   = IW'(idx_q + 1'b1);
        if (idx_q == IW'(NDIGITS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (mask_c) begin
          sum_d  = '0;
          cout_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_q, bad_d, err_q, err_d, in_bad_c;

  always_comb begin
    in_bad_c = 1'b0;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) in_bad_c = 1'b1;
    end
  end

  // Bad-digit status is captured with the operands and published at completion.
  always_comb begin
    bad_d = bad_q;
    err_d = err_q;
    if ((state_q == S_IDLE) && start) begin
      bad_d = in_bad_c;
      err_d = 1'b0;
    end else if ((state_q == S_DONE) && bad_q) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
      err_q <= err_d;
    end
  end

  assign mask_c = bad_q;
  assign err    = err_q;
`else
  assign mask_c = 1'b0;
  assign err    = 1'b0;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
